// File: rtl/prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : prefetch_buffer
// Brief    : Instruction prefetch FIFO with single-outstanding RAM fetch and
//            branch redirect/abort; optional response bypass (PREFETCH_BYPASS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module prefetch_buffer #(
  parameter int          DEPTH      = 2,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  localparam int         RISCV_ADDR_WIDTH = 32,
  localparam int         RISCV_WORD_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        branch_i,
  input  logic [RISCV_ADDR_WIDTH-1:0] branch_addr_i,
  output logic                        instr_valid_o,
  input  logic                        instr_ready_i,
  output logic [RISCV_WORD_WIDTH-1:0] instr_rdata_o,
  output logic [RISCV_ADDR_WIDTH-1:0] instr_addr_o,
  output logic                        mem_valid_o,
  input  logic                        mem_ready_i,
  output logic [RISCV_ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [RISCV_WORD_WIDTH-1:0] mem_rdata_i
);

  localparam int                 c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                 c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t                      r_state, w_state_nxt;
  logic [c_cnt_w-1:0]          r_count, w_count_nxt;
  logic [c_ptr_w-1:0]          r_rd_ptr, r_wr_ptr;
  logic [RISCV_ADDR_WIDTH-1:0] r_fetch_addr, w_fetch_addr_nxt;
  logic                        r_mem_valid, w_mem_valid_nxt;
  logic [RISCV_ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [RISCV_ADDR_WIDTH-1:0] r_fifo_addr [DEPTH];
  logic [RISCV_WORD_WIDTH-1:0] r_fifo_data [DEPTH];

  logic                        w_resp, w_bypass, w_push, w_pop, w_fifo_pop;
  logic [RISCV_ADDR_WIDTH-1:0] w_branch_target, w_fetch_inc;
  logic                        w_unused;

  assign w_branch_target = {branch_addr_i[RISCV_ADDR_WIDTH-1:2], 2'b00};
  assign w_fetch_inc     = r_fetch_addr + 32'd4;
  assign w_unused        = &{1'b0, branch_addr_i[1:0]};

  // A response is kept only when it answers a live (non-aborted) request
  assign w_resp = (r_state == WAIT) && mem_ready_i && !branch_i;

`ifdef PREFETCH_BYPASS_EN
  assign w_bypass      = w_resp && (r_count == '0);
  assign instr_valid_o = (r_count != '0) || w_bypass;
  assign instr_addr_o  = w_bypass ? r_fetch_addr : r_fifo_addr[r_rd_ptr];
  assign instr_rdata_o = w_bypass ? mem_rdata_i  : r_fifo_data[r_rd_ptr];
`else
  assign w_bypass      = 1'b0;
  assign instr_valid_o = (r_count != '0);
  assign instr_addr_o  = r_fifo_addr[r_rd_ptr];
  assign instr_rdata_o = r_fifo_data[r_rd_ptr];
`endif

  assign w_pop      = instr_valid_o && instr_ready_i && !branch_i;
  assign w_fifo_pop = w_pop && (r_count != '0);
  assign w_push     = w_resp && !(w_bypass && instr_ready_i);

  assign mem_valid_o = r_mem_valid;
  assign mem_addr_o  = r_mem_addr;

  always_comb begin
    w_state_nxt      = r_state;
    w_fetch_addr_nxt = r_fetch_addr;
    w_mem_valid_nxt  = r_mem_valid;
    w_mem_addr_nxt   = r_mem_addr;
    w_count_nxt      = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_fifo_pop);
    if (branch_i) begin
      w_count_nxt      = '0;
      w_fetch_addr_nxt = w_branch_target;
      if (r_state != IDLE && mem_ready_i) begin
        w_state_nxt     = IDLE;
        w_mem_valid_nxt = 1'b0;
      end else if (r_state == WAIT) begin
        w_state_nxt = ABORT;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (r_count < c_depth) begin
            w_state_nxt     = WAIT;
            w_mem_valid_nxt = 1'b1;
            w_mem_addr_nxt  = r_fetch_addr;
          end
        end
        WAIT: begin
          if (mem_ready_i) begin
            w_fetch_addr_nxt = w_fetch_inc;
            // Back-to-back re-issue keeps mem_valid_o high with the new address
            if (w_count_nxt < c_depth) begin
              w_mem_addr_nxt = w_fetch_inc;
            end else begin
              w_state_nxt     = IDLE;
              w_mem_valid_nxt = 1'b0;
            end
          end
        end
        ABORT: begin
          if (mem_ready_i) begin
            w_state_nxt     = IDLE;
            w_mem_valid_nxt = 1'b0;
          end
        end
        default: begin
          w_state_nxt     = IDLE;
          w_mem_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_fetch_addr <= RESET_ADDR;
      r_mem_valid  <= 1'b0;
      r_mem_addr   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_fetch_addr <= w_fetch_addr_nxt;
      r_mem_valid  <= w_mem_valid_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      if (branch_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_fifo_pop) r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
        if (w_push)     r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_addr[i] <= '0;
        r_fifo_data[i] <= '0;
      end
    end else if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= r_fetch_addr;
      r_fifo_data[r_wr_ptr] <= mem_rdata_i;
    end
  end

endmodule
`default_nettype wire
